// File: rtl/clk_period_meter.sv
// Measures the period of a slow signal in clk_i cycles, averaged over 2^AVG_LOG2 periods.
// Define CLK_PERIOD_METER_DUTY_EN to add the averaged high-time output high_o.
module clk_period_meter #(
  parameter int unsigned COUNT_W     = 24,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clk_meas_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [COUNT_W-1:0] period_o,
`ifdef CLK_PERIOD_METER_DUTY_EN
  output logic [COUNT_W-1:0] high_o,
`endif
  output logic               timeout_o
);

  localparam int unsigned ACC_W = COUNT_W + AVG_LOG2;
  localparam int unsigned IDX_W = AVG_LOG2 + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEASURE, ST_DONE} state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     hist_q;
  logic                     edge_q;
  logic [COUNT_W-1:0]       cnt_q;
  logic [ACC_W-1:0]         acc_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     busy_q;
  logic                     valid_q;
  logic                     timeout_q;
  logic [COUNT_W-1:0]       period_q;

  logic [COUNT_W-1:0]       cnt_d;
  logic [COUNT_W:0]         sample;
  logic [ACC_W-1:0]         acc_d;

  // Edge is registered so hist_q is the input level aligned with edge_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_meas_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  always_comb begin
    cnt_d  = cnt_q + COUNT_W'(1);
    sample = {1'b0, cnt_q} + (COUNT_W+1)'(1);
    acc_d  = acc_q + ACC_W'(sample);
  end

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [COUNT_W-1:0] hcnt_q;
  logic [ACC_W-1:0]   hacc_q;
  logic [COUNT_W-1:0] high_q;
  logic [COUNT_W:0]   hsample;
  logic [ACC_W-1:0]   hacc_d;

  always_comb begin
    hsample = {1'b0, hcnt_q} + (COUNT_W+1)'(hist_q);
    hacc_d  = hacc_q + ACC_W'(hsample);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      hacc_q <= '0;
      high_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            hcnt_q <= '0;
            hacc_q <= '0;
          end
        end
        ST_ARM: begin
          if (edge_q) begin
            hcnt_q <= '0;
          end else if (cnt_d == CNT_MAX) begin
            high_q <= hist_q ? '1 : '0;
          end
        end
        ST_MEASURE: begin
          if (edge_q) begin
            hacc_q <= hacc_d;
            hcnt_q <= '0;
            if (idx_q == IDX_LAST) high_q <= hacc_d[ACC_W-1:AVG_LOG2];
          end else if (cnt_d == CNT_MAX) begin
            high_q <= hist_q ? '1 : '0;
          end else if (hist_q) begin
            hcnt_q <= hcnt_q + COUNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign high_o = high_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      period_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (edge_q) begin
            state_q <= ST_MEASURE;
            cnt_q   <= '0;
          end else if (cnt_d == CNT_MAX) begin
            state_q   <= ST_DONE;
            cnt_q     <= cnt_d;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            period_q  <= '1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_MEASURE: begin
          // Edge takes priority over a timeout in the same cycle.
          if (edge_q) begin
            acc_q <= acc_d;
            cnt_q <= '0;
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              period_q  <= acc_d[ACC_W-1:AVG_LOG2];
            end
          end else if (cnt_d == CNT_MAX) begin
            state_q   <= ST_DONE;
            cnt_q     <= cnt_d;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            period_q  <= '1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign period_o  = period_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter against an arithmetic reference of averaged periods.
module tb_clk_period_meter;
  localparam int unsigned CW = 8;
  localparam int unsigned AL = 2;
  localparam int unsigned SS = 2;
  localparam int unsigned NAVG = 1 << AL;

  logic          clk = 1'b0;
  logic          rst, clk_meas, start, ready;
  logic          busy, valid, timeout;
  logic [CW-1:0] period;
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CW-1:0] high;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned hi_a[NAVG];
  int unsigned lo_a[NAVG];

  clk_period_meter #(.COUNT_W(CW), .AVG_LOG2(AL), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_i(rst), .clk_meas_i(clk_meas), .start_i(start),
    .busy_o(busy), .valid_o(valid), .ready_i(ready), .period_o(period),
`ifdef CLK_PERIOD_METER_DUTY_EN
    .high_o(high),
`endif
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input string tag, input int unsigned hold);
    logic [CW-1:0] p0;
    logic          t0;
    bit            stable;
    p0 = period; t0 = timeout; stable = 1;
    for (int unsigned i = 0; i < hold; i++) begin
      start = (i == hold / 2);
      tick();
      start = 1'b0;
      if (!valid || period !== p0 || timeout !== t0 || busy) stable = 0;
    end
    check_eq({tag, "_hold_stable"}, 32'(stable), 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(valid), 0);
    tick();
    check_eq({tag, "_idle_after"}, 32'(busy), 0);
  endtask

  task automatic do_measure(input string tag, input int unsigned hold);
    int unsigned exp_p, exp_h, k;
    bit seen;
    exp_p = 0; exp_h = 0;
    for (int unsigned i = 0; i < NAVG; i++) begin
      exp_p += hi_a[i] + lo_a[i];
      exp_h += hi_a[i];
    end
    exp_p = exp_p / NAVG;
    exp_h = exp_h / NAVG;
    clk_meas = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq({tag, "_busy"}, 32'(busy), 1);
    for (int unsigned i = 0; i < NAVG; i++) begin
      clk_meas = 1'b1;
      repeat (hi_a[i]) tick();
      clk_meas = 1'b0;
      repeat (lo_a[i]) tick();
    end
    check_eq({tag, "_no_early_valid"}, 32'(valid), 0);
    clk_meas = 1'b1;
    k = 0; seen = 0;
    while (k < 20 && !seen) begin
      tick();
      k++;
      if (valid) seen = 1;
    end
    check_eq({tag, "_latency"}, k, SS + 2);
    check_eq({tag, "_busy_done"}, 32'(busy), 0);
    check_eq({tag, "_timeout"}, 32'(timeout), 0);
    check_eq({tag, "_period"}, 32'(period), exp_p);
`ifdef CLK_PERIOD_METER_DUTY_EN
    check_eq({tag, "_high"}, 32'(high), exp_h);
`endif
    clk_meas = 1'b0;
    handshake(tag, hold);
  endtask

  task automatic do_timeout(input string tag, input logic level);
    int unsigned k;
    bit seen;
    clk_meas = level;
    repeat (5) tick();
    start = 1'b1;
    k = 0; seen = 0;
    while (k < 400 && !seen) begin
      tick();
      start = 1'b0;
      k++;
      if (valid) seen = 1;
    end
    // One cycle to enter ARM, then 255 cycles to reach the counter limit.
    check_eq({tag, "_cycles"}, k, 1 + (1 << CW) - 1);
    check_eq({tag, "_period"}, 32'(period), (1 << CW) - 1);
    check_eq({tag, "_timeout"}, 32'(timeout), 1);
`ifdef CLK_PERIOD_METER_DUTY_EN
    check_eq({tag, "_high"}, 32'(high), level ? (1 << CW) - 1 : 0);
`endif
    handshake(tag, 3);
  endtask

  initial begin
    rst = 1'b1; clk_meas = 1'b0; start = 1'b0; ready = 1'b0;
    tick(); tick();
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_period", 32'(period), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
    repeat (3) tick();

    for (int unsigned i = 0; i < NAVG; i++) begin hi_a[i] = 5; lo_a[i] = 5; end
    do_measure("p10", 20);

    for (int unsigned i = 0; i < NAVG; i++) begin hi_a[i] = 3 + (i % 2); lo_a[i] = 4; end
    do_measure("p7_8", 1);

    for (int unsigned i = 0; i < NAVG; i++) begin hi_a[i] = 3; lo_a[i] = 7; end
    do_measure("duty3_7", 0);

    for (int unsigned r = 0; r < 8; r++) begin
      for (int unsigned i = 0; i < NAVG; i++) begin
        hi_a[i] = $urandom_range(2, 12);
        lo_a[i] = $urandom_range(2, 12);
      end
      do_measure($sformatf("rnd%0d", r), $urandom_range(0, 6));
    end

    do_timeout("to_low", 1'b0);
    do_timeout("to_high", 1'b1);

    for (int unsigned i = 0; i < NAVG; i++) begin hi_a[i] = 6; lo_a[i] = 6; end
    do_measure("pre_rst", 2);
    clk_meas = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int unsigned i = 0; i < 2; i++) begin
      clk_meas = 1'b1; repeat (6) tick();
      clk_meas = 1'b0; repeat (6) tick();
    end
    check_eq("mid_busy", 32'(busy), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("async_valid", 32'(valid), 0);
    check_eq("async_busy", 32'(busy), 0);
    check_eq("async_period", 32'(period), 0);
    check_eq("async_timeout", 32'(timeout), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    do_measure("post_rst", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Measures the period of a slow clock-like signal, such as a divided clock or an external tick, in cycles of the fast system clock.
- Averages the result over 2^AVG_LOG2 periods.
- Returns the result through a valid/ready handshake.
- Used as the receive-side check for clock dividers: it recovers the division ratio and confirms an expected output frequency at runtime.

Parameters:
COUNT_W, 24, width of the per-period counter and of period_o; also sets the timeout limit of 2^COUNT_W-1 cycles
AVG_LOG2, 2, log2 of the number of periods averaged (0 = single period)
SYNC_STAGES, 2, flip-flop stages in the synchronizer on clk_meas_i (minimum 2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
clk_meas_i  input  1  signal to measure, asynchronous to clk_i
start_i  input  1  single-cycle request to begin a measurement
busy_o  output  1  high while a measurement is in progress (ARM or MEASURE)
valid_o  output  1  result available
ready_i  input  1  consumer accepts the result
period_o  output  COUNT_W  averaged period in clk_i cycles
timeout_o  output  1  result is a timeout, not a measurement

Behaviour:
- Reset values (async assert): state IDLE; valid_o=0, busy_o=0, period_o=0, timeout_o=0; all counters and synchronizer flops 0.
- Synchronizer: SYNC_STAGES flops on clk_meas_i, plus one history flop.
- Rising edge ("edge") = synchronized output is 1 and history flop is 0. The edge is a one-cycle pulse, SYNC_STAGES+1 cycles after the input transition.
- Input constraint: high and low phases each ≥ 2 clk_i cycles. Shorter phases are out of contract.
- States:
  - IDLE: start_i=1 -> ARM; clear the cycle counter, accumulator and period index. Other inputs are ignored.
  - ARM: waits for the first edge. On edge -> MEASURE; cycle counter := 0.
  - MEASURE: cycle counter increments every cycle. On edge:
    - sample = counter+1; accumulator += sample; counter := 0; index += 1.
    - When index reaches 2^AVG_LOG2 -> DONE; period_o := accumulator >> AVG_LOG2 (truncating); timeout_o := 0.
  - DONE: valid_o=1. The result stays stable while ready_i=0. When valid_o&&ready_i -> IDLE and valid_o falls next cycle. start_i in DONE is ignored.
- Timeout: in ARM or MEASURE, when the cycle counter reaches 2^COUNT_W-1 without an edge -> DONE with period_o = all ones and timeout_o=1. The counter saturates and never wraps.
- Accumulator width is COUNT_W+AVG_LOG2, so it cannot overflow before the timeout triggers.
- Edge and timeout in the same cycle: the edge wins and the sample is recorded.
- busy_o = (state==ARM || state==MEASURE), driven from registered state.
- start_i and ready_i are sampled on clk_i; they need no synchronization.
- Reset asserted mid-measurement: returns immediately to IDLE with all outputs at reset values; the partial measurement is discarded.
- Latency from the final qualifying input edge to valid_o: SYNC_STAGES+2 clk_i cycles.

Optional Feature:
Macro: CLK_PERIOD_METER_DUTY_EN.
- Defined:
  - Adds output high_o [COUNT_W] (reset 0) and a second counter that increments in MEASURE while the synchronized input is 1.
  - Accumulated per period like the period sample; high_o := high_acc >> AVG_LOG2 on entering DONE.
  - On timeout, high_o = all ones if the input is stuck high, else 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- AVG_LOG2=2, clk_meas_i period 10 cycles (5 high/5 low), pulse start_i -> valid_o rises after 5 rising edges; period_o=10, timeout_o=0, busy_o low in the same cycle valid_o rises.
- Alternating periods 7 and 8 cycles, AVG_LOG2=2 -> accumulator 30, period_o=7 (truncation).
- COUNT_W=8, clk_meas_i held 0 after start_i -> DONE 255 cycles after entering ARM; period_o=8'hFF, timeout_o=1.
- ready_i held low for 20 cycles after valid_o -> valid_o, period_o and timeout_o stable throughout; one cycle after ready_i=1, valid_o=0. start_i pulsed during DONE is ignored.
- rst_i asserted asynchronously mid-MEASURE (between clock edges) -> outputs reach reset values without waiting for clk_i. After release, start_i gives a correct fresh measurement of period 12.
- With CLK_PERIOD_METER_DUTY_EN defined: 3 high/7 low, AVG_LOG2=1 -> period_o=10, high_o=3.
